// File: rtl/board_mem_hist.sv
// board_mem_hist
// Game-board memory holding a SIDE x SIDE grid of CELL_W-bit cells, where the
// value 0 means empty. The block accepts validated single-cell writes and
// keeps a bounded LIFO of moves so the controller can undo them. When the
// history is full, pushing a new move drops the oldest entry.
//
// Ports
//   clk       system clock; all state changes on the rising edge
//   reset     synchronous, active-high
//   wr_en     write request
//   wr_addr   cell index (row*SIDE + col)
//   wr_state  value to write; 0 is illegal
//   undo      pop the last move and restore the previous cell value
//   clear     empty the board and the history in one cycle
//   gBoard    flat board; cell i sits at gBoard[i*CELL_W +: CELL_W]
//   wr_ack    one-cycle pulse: the previous-cycle write was accepted
//   wr_err    one-cycle pulse: the previous-cycle write was rejected
//   occ_cnt   number of non-empty cells
//   full      high when every cell is occupied
//   hist_cnt  number of valid history entries
module board_mem_hist #(
    parameter int SIDE       = 3,
    parameter int CELL_W     = 2,
    parameter int HIST_DEPTH = 9,
    parameter int OVERWRITE  = 0,
    localparam int CELLS     = SIDE * SIDE,
    localparam int AW        = $clog2(CELLS),
    localparam int OW        = $clog2(CELLS + 1),
    localparam int HW        = $clog2(HIST_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [CELL_W-1:0]       wr_state,
    input  logic                    undo,
    input  logic                    clear,
    output logic [CELLS*CELL_W-1:0] gBoard,
    output logic                    wr_ack,
    output logic                    wr_err,
    output logic [OW-1:0]           occ_cnt,
    output logic                    full,
    output logic [HW-1:0]           hist_cnt
);
    localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    logic [CELL_W-1:0] cells     [CELLS];
    logic [AW-1:0]     hist_addr [HIST_DEPTH];
    logic [CELL_W-1:0] hist_val  [HIST_DEPTH];

    // wp is the slot the next push writes. When the history is full, that
    // slot holds the oldest entry, so a push overwrites it naturally.
    logic [PW-1:0]     wp, wp_nxt, top;
    logic [CELL_W-1:0] old_val, pop_val;
    logic [AW-1:0]     pop_addr;
    logic              addr_ok, do_write, do_undo, err_nxt;
    logic [OW-1:0]     occ_nxt;
    logic [HW-1:0]     hcnt_nxt;

    for (genvar g = 0; g < CELLS; g++) begin : g_flat
        assign gBoard[g*CELL_W +: CELL_W] = cells[g];
    end

    always_comb begin
        // Out-of-range addresses match no cell and read back as empty. Such
        // writes are rejected anyway, so the value read here is never used.
        old_val = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (wr_addr == AW'(i)) old_val = cells[i];
        end
        addr_ok  = 32'(wr_addr) < 32'(CELLS);
        top      = (wp == '0) ? PW'(HIST_DEPTH - 1) : wp - 1'b1;
        pop_addr = hist_addr[top];
        pop_val  = hist_val[top];

        // A raised undo blocks the write even when the history is empty.
        do_undo  = !clear && undo && (hist_cnt != '0);
        do_write = !clear && !undo && wr_en && addr_ok && (wr_state != '0)
                   && ((old_val == '0) || (OVERWRITE != 0));
        err_nxt  = wr_en && !do_write;

        occ_nxt  = occ_cnt;
        hcnt_nxt = hist_cnt;
        wp_nxt   = wp;
        if (clear) begin
            occ_nxt  = '0;
            hcnt_nxt = '0;
            wp_nxt   = '0;
        end else if (do_undo) begin
            hcnt_nxt = hist_cnt - 1'b1;
            wp_nxt   = top;
            if (pop_val == '0) occ_nxt = occ_cnt - 1'b1;
        end else if (do_write) begin
            if (old_val == '0) occ_nxt = occ_cnt + 1'b1;
            wp_nxt = (wp == PW'(HIST_DEPTH - 1)) ? '0 : wp + 1'b1;
            if (hist_cnt != HW'(HIST_DEPTH)) hcnt_nxt = hist_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            hist_cnt <= '0;
            occ_cnt  <= '0;
            full     <= 1'b0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            wp       <= wp_nxt;
            hist_cnt <= hcnt_nxt;
            occ_cnt  <= occ_nxt;
            full     <= (occ_nxt == OW'(CELLS));
            wr_ack   <= do_write;
            wr_err   <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CELLS; i++) begin
            if (reset || clear)                            cells[i] <= '0;
            else if (do_write && (wr_addr == AW'(i)))      cells[i] <= wr_state;
            else if (do_undo && (pop_addr == AW'(i)))      cells[i] <= pop_val;
        end
    end

    // History contents need no reset; hist_cnt decides which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            hist_addr[wp] <= wr_addr;
            hist_val[wp]  <= old_val;
        end
    end
endmodule

// File: tb/tb_board_mem_hist.sv
// tb_board_mem_hist
// Drives three board_mem_hist instances with identical stimulus:
//   c0 default (HIST_DEPTH=9, OVERWRITE=0)
//   c1 HIST_DEPTH=2
//   c2 OVERWRITE=1
// A behavioural model, whose history is a shift-down array, predicts each
// instance's outputs. Predictions are queued when a command is driven and
// compared once the following clock edge has produced the DUT response.
module tb_board_mem_hist;
    typedef struct packed {
        logic [17:0] board;
        logic        ack;
        logic        err;
        logic [3:0]  occ;
        logic        full;
        logic [3:0]  hist;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, wr_en, undo, clear;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_state;

    logic [17:0] gb0, gb1, gb2;
    logic        ack0, ack1, ack2, err0, err1, err2, full0, full1, full2;
    logic [3:0]  occ0, occ1, occ2, hc0, hc2;
    logic [1:0]  hc1;

    board_mem_hist #(.SIDE(3), .CELL_W(2), .HIST_DEPTH(9), .OVERWRITE(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_state(wr_state),
        .undo(undo), .clear(clear), .gBoard(gb0), .wr_ack(ack0), .wr_err(err0),
        .occ_cnt(occ0), .full(full0), .hist_cnt(hc0));
    board_mem_hist #(.SIDE(3), .CELL_W(2), .HIST_DEPTH(2), .OVERWRITE(0)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_state(wr_state),
        .undo(undo), .clear(clear), .gBoard(gb1), .wr_ack(ack1), .wr_err(err1),
        .occ_cnt(occ1), .full(full1), .hist_cnt(hc1));
    board_mem_hist #(.SIDE(3), .CELL_W(2), .HIST_DEPTH(9), .OVERWRITE(1)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_state(wr_state),
        .undo(undo), .clear(clear), .gBoard(gb2), .wr_ack(ack2), .wr_err(err2),
        .occ_cnt(occ2), .full(full2), .hist_cnt(hc2));

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    int dep [3];
    int ov  [3];
    int mb  [3][9];
    int mh_a[3][16];
    int mh_v[3][16];
    int mhc [3];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model(input int k, input bit r, input bit we, input int a, input int s,
                         input bit u, input bit c, output exp_t e);
        int occ;
        e = '0;
        if (r || c) begin
            for (int i = 0; i < 9; i++) mb[k][i] = 0;
            mhc[k] = 0;
            e.err  = !r && we;
        end else if (u) begin
            if (mhc[k] > 0) begin
                mhc[k]--;
                mb[k][mh_a[k][mhc[k]]] = mh_v[k][mhc[k]];
            end
            e.err = we;
        end else if (we) begin
            if (a < 9 && s != 0 && (mb[k][a] == 0 || ov[k] != 0)) begin
                if (mhc[k] == dep[k]) begin
                    for (int j = 0; j < dep[k] - 1; j++) begin
                        mh_a[k][j] = mh_a[k][j+1];
                        mh_v[k][j] = mh_v[k][j+1];
                    end
                    mh_a[k][dep[k]-1] = a;
                    mh_v[k][dep[k]-1] = mb[k][a];
                end else begin
                    mh_a[k][mhc[k]] = a;
                    mh_v[k][mhc[k]] = mb[k][a];
                    mhc[k]++;
                end
                mb[k][a] = s;
                e.ack    = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end
        occ = 0;
        for (int i = 0; i < 9; i++) begin
            e.board[i*2 +: 2] = 2'(mb[k][i]);
            if (mb[k][i] != 0) occ++;
        end
        e.occ  = 4'(occ);
        e.full = (occ == 9);
        e.hist = 4'(mhc[k]);
    endtask

    task automatic compare(input int k);
        exp_t e;
        int   g_b, g_a, g_e, g_o, g_f, g_h;
        if (sb.size() == 0) begin
            check($sformatf("c%0d.sb_empty", k), 0, 1);
            return;
        end
        e = sb.pop_front();
        case (k)
            0:       begin g_b = int'(gb0); g_a = int'(ack0); g_e = int'(err0); g_o = int'(occ0); g_f = int'(full0); g_h = int'(hc0); end
            1:       begin g_b = int'(gb1); g_a = int'(ack1); g_e = int'(err1); g_o = int'(occ1); g_f = int'(full1); g_h = int'(hc1); end
            default: begin g_b = int'(gb2); g_a = int'(ack2); g_e = int'(err2); g_o = int'(occ2); g_f = int'(full2); g_h = int'(hc2); end
        endcase
        check($sformatf("c%0d.board", k), g_b, int'(e.board));
        check($sformatf("c%0d.wr_ack", k), g_a, int'(e.ack));
        check($sformatf("c%0d.wr_err", k), g_e, int'(e.err));
        check($sformatf("c%0d.occ_cnt", k), g_o, int'(e.occ));
        check($sformatf("c%0d.full", k), g_f, int'(e.full));
        check($sformatf("c%0d.hist_cnt", k), g_h, int'(e.hist));
    endtask

    task automatic step(input bit r, input bit we, input int a, input int s,
                        input bit u, input bit c);
        exp_t e;
        reset    = r;
        wr_en    = we;
        wr_addr  = 4'(a);
        wr_state = 2'(s);
        undo     = u;
        clear    = c;
        for (int k = 0; k < 3; k++) begin
            model(k, r, we, a, s, u, c, e);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) compare(k);
    endtask

    task automatic wr(input int a, input int s);
        step(1'b0, 1'b1, a, s, 1'b0, 1'b0);
    endtask

    task automatic do_undo();
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        dep = '{9, 2, 9};
        ov  = '{0, 0, 1};
        for (int k = 0; k < 3; k++) mhc[k] = 0;

        // Reset for two cycles, then one idle cycle.
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle();

        // Write to an empty cell, then write to the same occupied cell.
        wr(4, 1);
        wr(4, 2);

        // Out-of-range address, then an illegal zero value.
        wr(9, 1);
        wr(2, 0);
        wr(15, 3);

        // Fill the whole board, then undo three times (c1 runs its history dry).
        do_clear();
        for (int i = 0; i < 9; i++) wr(i, (i % 2) ? 2 : 1);
        idle();
        for (int i = 0; i < 3; i++) do_undo();

        // Shallow-history case: write cells 0, 1, 2, then undo three times.
        do_clear();
        wr(0, 1);
        wr(1, 2);
        wr(2, 3);
        for (int i = 0; i < 3; i++) do_undo();

        // Clear, undo and write in the same cycle, then an overwrite and its undo.
        wr(5, 2);
        step(1'b0, 1'b1, 3, 1, 1'b1, 1'b1);
        wr(3, 1);
        wr(3, 2);
        do_undo();

        // Undo together with a write, including undo on an empty history.
        step(1'b0, 1'b1, 6, 1, 1'b1, 1'b0);
        do_clear();
        step(1'b0, 1'b1, 6, 1, 1'b1, 1'b0);

        // Reset in the middle of a sequence, then one idle cycle.
        wr(7, 1);
        wr(8, 2);
        step(1'b1, 1'b1, 0, 1, 1'b0, 1'b0);
        idle();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 40) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
